buffer_read_ctrl: RTL and testbench

//  Readout sequencer for the raw-hits FIFO RAM; counterpart to the fence-based write controller.
//  On a readout request it takes the event at the head of the fence queue and sets the read start back by the pretrig tbins.
//  It then streams fifo_tbins consecutive RAM addresses with a latency-aligned valid strobe.

---
 rtl/buffer_read_ctrl_pkg.sv | 28 ++
 rtl/buffer_read_ctrl_if.sv | 36 +++
 rtl/buffer_read_ctrl_rd_valid_pipe.sv | 29 ++
 rtl/buffer_read_ctrl.sv | 132 +++++++++++++
 tb/tb_buffer_read_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/buffer_read_ctrl_pkg.sv
// rtl/buffer_read_ctrl_pkg.sv - shared widths, state encoding and helpers for the raw-hits read sequencer
package buffer_read_ctrl_pkg;

  localparam int MXTBIN   = 5;
  localparam int RAM_ADRB = 11;
  localparam int MXBDATA  = 32;

  typedef enum logic [2:0] {
    bsm_rd_idle  = 3'd0,
    bsm_rd_latch = 3'd1,
    bsm_rd_read  = 3'd2,
    bsm_rd_flush = 3'd3,
    bsm_rd_pop   = 3'd4
  } bsm_rd_state_e;

  // Readout begins pretrig tbins before the fenced pretrigger address; wraps with the RAM.
  function automatic logic [RAM_ADRB-1:0] rd_start_adr(
    input logic [RAM_ADRB-1:0] queue_adr,
    input logic [MXTBIN-1:0]   pretrig
  );
    return queue_adr - RAM_ADRB'(pretrig);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/buffer_read_ctrl_if.sv
// rtl/buffer_read_ctrl_if.sv - fence-queue, config and RAM-read signals of the read sequencer
interface buffer_read_ctrl_if;
  import buffer_read_ctrl_pkg::*;

  logic                rd_start;
  logic                rd_hold;
  logic [MXTBIN-1:0]   fifo_tbins;
  logic [MXTBIN-1:0]   fifo_pretrig;
  logic                buf_q_empty;
  logic [RAM_ADRB-1:0] buf_queue_adr;
  logic [MXBDATA-1:0]  buf_queue_data;

  logic                fifo_ren;
  logic [RAM_ADRB-1:0] fifo_radr;
  logic                rd_valid;
  logic [MXTBIN-1:0]   rd_tbin;
  logic [MXBDATA-1:0]  rd_event_data;
  logic                rd_busy;
  logic                buf_pop;
  logic [RAM_ADRB-1:0] buf_pop_adr;
  logic                rd_udf_err;
  logic [15:0]         rd_event_cnt;

  modport master (
    input  rd_start, rd_hold, fifo_tbins, fifo_pretrig, buf_q_empty, buf_queue_adr, buf_queue_data,
    output fifo_ren, fifo_radr, rd_valid, rd_tbin, rd_event_data, rd_busy, buf_pop, buf_pop_adr,
           rd_udf_err, rd_event_cnt
  );

  modport slave (
    output rd_start, rd_hold, fifo_tbins, fifo_pretrig, buf_q_empty, buf_queue_adr, buf_queue_data,
    input  fifo_ren, fifo_radr, rd_valid, rd_tbin, rd_event_data, rd_busy, buf_pop, buf_pop_adr,
           rd_udf_err, rd_event_cnt
  );

endinterface

// File: rtl/buffer_read_ctrl_rd_valid_pipe.sv
// rtl/buffer_read_ctrl_rd_valid_pipe.sv - LATENCY-deep shift register aligning {ren, tbin} with RAM data out
module buffer_read_ctrl_rd_valid_pipe #(
  parameter int LATENCY = 1,
  parameter int WIDTH   = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [LATENCY];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[LATENCY-1];

endmodule

// File: rtl/buffer_read_ctrl.sv
// rtl/buffer_read_ctrl.sv - reads the head-of-queue event out of the raw-hits RAM and releases its fence
module buffer_read_ctrl
  import buffer_read_ctrl_pkg::*;
#(
  parameter int RAM_LATENCY = 1
) (
  input logic               clock,
  input logic               reset_n,
  buffer_read_ctrl_if.master bus
);

  bsm_rd_state_e       state_q, state_d;
  logic [RAM_ADRB-1:0] radr_q, radr_d;
  logic [RAM_ADRB-1:0] pop_adr_q, pop_adr_d;
  logic [MXTBIN-1:0]   tbin_q, tbin_d;
  logic [MXTBIN-1:0]   tbins_q, tbins_d;
  logic [MXBDATA-1:0]  data_q, data_d;
  logic [2:0]          flush_cnt_q, flush_cnt_d;
  logic                udf_q, udf_d;
  logic [15:0]         evcnt_q, evcnt_d;
  logic                ren;
  logic [MXTBIN:0]     pipe_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= bsm_rd_idle;
      radr_q      <= '0;
      pop_adr_q   <= '0;
      tbin_q      <= '0;
      tbins_q     <= '0;
      data_q      <= '0;
      flush_cnt_q <= '0;
      udf_q       <= 1'b0;
      evcnt_q     <= '0;
    end else begin
      state_q     <= state_d;
      radr_q      <= radr_d;
      pop_adr_q   <= pop_adr_d;
      tbin_q      <= tbin_d;
      tbins_q     <= tbins_d;
      data_q      <= data_d;
      flush_cnt_q <= flush_cnt_d;
      udf_q       <= udf_d;
      evcnt_q     <= evcnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    radr_d      = radr_q;
    pop_adr_d   = pop_adr_q;
    tbin_d      = tbin_q;
    tbins_d     = tbins_q;
    data_d      = data_q;
    flush_cnt_d = flush_cnt_q;
    udf_d       = udf_q;
    evcnt_d     = evcnt_q;
    ren         = 1'b0;

    case (state_q)
      bsm_rd_idle: begin
        if (bus.rd_start) begin
          if (bus.buf_q_empty) begin
            udf_d = 1'b1;
          end else begin
            state_d = bsm_rd_latch;
          end
        end
      end

      // Config and queue head are sampled here only; later changes cannot disturb the event.
      bsm_rd_latch: begin
        pop_adr_d   = bus.buf_queue_adr;
        data_d      = bus.buf_queue_data;
        radr_d      = rd_start_adr(bus.buf_queue_adr, bus.fifo_pretrig);
        tbin_d      = '0;
        tbins_d     = bus.fifo_tbins;
        flush_cnt_d = '0;
        state_d     = (bus.fifo_tbins == '0) ? bsm_rd_flush : bsm_rd_read;
      end

      bsm_rd_read: begin
        ren = !bus.rd_hold;
        if (ren) begin
          radr_d = radr_q + RAM_ADRB'(1);
          tbin_d = tbin_q + MXTBIN'(1);
          if (tbin_q == tbins_q - MXTBIN'(1)) begin
            state_d = bsm_rd_flush;
          end
        end
      end

      // Hold the fence until the last RAM word has emerged from the valid pipe.
      bsm_rd_flush: begin
        if (flush_cnt_q == 3'(RAM_LATENCY - 1)) begin
          state_d = bsm_rd_pop;
        end else begin
          flush_cnt_d = flush_cnt_q + 3'd1;
        end
      end

      bsm_rd_pop: begin
        evcnt_d = sat_inc16(evcnt_q);
        state_d = bsm_rd_idle;
      end

      default: state_d = bsm_rd_idle;
    endcase
  end

  buffer_read_ctrl_rd_valid_pipe #(
    .LATENCY (RAM_LATENCY),
    .WIDTH   (MXTBIN + 1)
  ) u_rd_valid_pipe (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .d_i    ({ren, tbin_q}),
    .q_o    (pipe_q)
  );

  assign bus.fifo_ren      = ren;
  assign bus.fifo_radr     = radr_q;
  assign bus.rd_valid      = pipe_q[MXTBIN];
  assign bus.rd_tbin       = pipe_q[MXTBIN-1:0];
  assign bus.rd_event_data = data_q;
  assign bus.rd_busy       = (state_q != bsm_rd_idle);
  assign bus.buf_pop       = (state_q == bsm_rd_pop);
  assign bus.buf_pop_adr   = pop_adr_q;
  assign bus.rd_udf_err    = udf_q;
  assign bus.rd_event_cnt  = evcnt_q;

endmodule

// File: tb/tb_buffer_read_ctrl.sv
// tb/tb_buffer_read_ctrl.sv - randomized self-checking bench for buffer_read_ctrl
module tb_buffer_read_ctrl;
  import buffer_read_ctrl_pkg::*;

  localparam int LAT = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  buffer_read_ctrl_if bus();

  buffer_read_ctrl #(.RAM_LATENCY(LAT)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int exp_evcnt = 0;
  bit exp_udf = 1'b0;

  task automatic drive_idle();
    bus.rd_start       = 1'b0;
    bus.rd_hold        = 1'b0;
    bus.fifo_tbins     = '0;
    bus.fifo_pretrig   = '0;
    bus.buf_q_empty    = 1'b0;
    bus.buf_queue_adr  = '0;
    bus.buf_queue_data = '0;
  endtask

  // Event starts at cycle 0 (rd_start high). Expected behaviour per cycle c:
  // ren when c>=2, fewer than n words issued and hold low; valid LAT cycles after each ren;
  // pop LAT+1 cycles after the last ren (2+LAT when n==0).
  task automatic run_event(input logic [10:0] a, input logic [4:0] p, input logic [4:0] n,
                           input logic [31:0] d, input int hold_from, input int hold_len,
                           input bit rand_hold, input bit noise);
    int ren_cnt, val_cnt, last_ren, exp_pop;
    bit hold, exp_ren, exp_valid, exp_busy, done;
    bit ren_hist [0:399];
    logic [10:0] exp_radr;
    ren_cnt = 0; val_cnt = 0; last_ren = -1; exp_pop = -1; done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      hold = (c >= hold_from && c < hold_from + hold_len) || (rand_hold && $urandom_range(0, 2) == 0);
      bus.rd_hold = hold;
      if (c == 0) begin
        bus.rd_start = 1'b1; bus.buf_q_empty = 1'b0; bus.buf_queue_adr = a;
        bus.fifo_pretrig = p; bus.fifo_tbins = n; bus.buf_queue_data = d;
      end else if (c == 1) begin
        bus.rd_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end else if (noise && c <= int'(n) + 1) begin
        bus.rd_start = 1'($urandom_range(0, 1)); bus.buf_q_empty = 1'($urandom_range(0, 1));
        bus.buf_queue_adr = 11'($urandom); bus.fifo_pretrig = 5'($urandom);
        bus.fifo_tbins = 5'($urandom); bus.buf_queue_data = $urandom;
      end else begin
        bus.rd_start = 1'b0; bus.buf_q_empty = 1'b0;
      end
      @(negedge clock);
      if (c == 0) begin
        checks++;
        if (bus.rd_event_cnt !== 16'(exp_evcnt)) begin
          errors++; $display("FAIL evcnt_at_start: got %0d exp %0d", bus.rd_event_cnt, exp_evcnt);
        end
        checks++;
        if (bus.rd_udf_err !== exp_udf) begin
          errors++; $display("FAIL udf_at_start: got %0b exp %0b", bus.rd_udf_err, exp_udf);
        end
      end
      exp_ren = (c >= 2) && (ren_cnt < int'(n)) && !hold;
      checks++;
      if (bus.fifo_ren !== exp_ren) begin
        errors++; $display("FAIL fifo_ren c=%0d: got %0b exp %0b", c, bus.fifo_ren, exp_ren);
      end
      if (c >= 2 && ren_cnt < int'(n)) begin
        exp_radr = a - 11'(p) + 11'(ren_cnt);
        checks++;
        if (bus.fifo_radr !== exp_radr) begin
          errors++; $display("FAIL fifo_radr c=%0d: got %0d exp %0d", c, bus.fifo_radr, exp_radr);
        end
      end
      ren_hist[c] = exp_ren;
      exp_valid = (c >= LAT) && ren_hist[c-LAT];
      checks++;
      if (bus.rd_valid !== exp_valid) begin
        errors++; $display("FAIL rd_valid c=%0d: got %0b exp %0b", c, bus.rd_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (bus.rd_tbin !== 5'(val_cnt)) begin
          errors++; $display("FAIL rd_tbin c=%0d: got %0d exp %0d", c, bus.rd_tbin, val_cnt);
        end
        val_cnt++;
      end
      if (exp_ren) begin
        ren_cnt++; last_ren = c;
      end
      if (n == 0) exp_pop = 2 + LAT;
      else if (ren_cnt == int'(n)) exp_pop = last_ren + LAT + 1;
      checks++;
      if (bus.buf_pop !== (c == exp_pop)) begin
        errors++; $display("FAIL buf_pop c=%0d: got %0b exp %0b", c, bus.buf_pop, c == exp_pop);
      end
      exp_busy = (c >= 1) && (exp_pop < 0 || c <= exp_pop);
      checks++;
      if (bus.rd_busy !== exp_busy) begin
        errors++; $display("FAIL rd_busy c=%0d: got %0b exp %0b", c, bus.rd_busy, exp_busy);
      end
      if (c == exp_pop) begin
        checks++;
        if (bus.buf_pop_adr !== a) begin
          errors++; $display("FAIL buf_pop_adr: got %0d exp %0d", bus.buf_pop_adr, a);
        end
        checks++;
        if (bus.rd_event_data !== d) begin
          errors++; $display("FAIL rd_event_data: got %0h exp %0h", bus.rd_event_data, d);
        end
        if (exp_evcnt < 65535) exp_evcnt++;
        done = 1'b1;
      end
      @(posedge clock); #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL event_timeout: got no pop exp pop within 400 cycles");
    end
    drive_idle();
  endtask

  task automatic test_reset();
    drive_idle();
    reset_n = 1'b0;
    #2;
    checks++;
    if ({bus.fifo_ren, bus.rd_valid, bus.rd_busy, bus.buf_pop, bus.rd_udf_err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %05b exp 00000",
                         {bus.fifo_ren, bus.rd_valid, bus.rd_busy, bus.buf_pop, bus.rd_udf_err});
    end
    checks++;
    if (bus.fifo_radr !== 11'd0 || bus.buf_pop_adr !== 11'd0 || bus.rd_tbin !== 5'd0) begin
      errors++; $display("FAIL reset_addrs: got radr=%0d popadr=%0d tbin=%0d exp 0",
                         bus.fifo_radr, bus.buf_pop_adr, bus.rd_tbin);
    end
    checks++;
    if (bus.rd_event_data !== 32'd0 || bus.rd_event_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_data: got data=%0h cnt=%0d exp 0", bus.rd_event_data, bus.rd_event_cnt);
    end
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_basic();
    run_event(11'd100, 5'd7, 5'd4, 32'hA5A5_0001, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    run_event(11'd3, 5'd7, 5'd8, 32'h0000_0BAD, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_hold();
    run_event(11'd200, 5'd5, 5'd4, 32'h1234_5678, 3, 3, 1'b0, 1'b0);
  endtask

  task automatic test_zero_tbins();
    run_event(11'd50, 5'd2, 5'd0, 32'hFEED_0000, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_underflow();
    bus.rd_start = 1'b1; bus.buf_q_empty = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checks++;
      if (bus.fifo_ren !== 1'b0 || bus.buf_pop !== 1'b0 || bus.rd_busy !== 1'b0) begin
        errors++; $display("FAIL udf_quiet c=%0d: got ren=%0b pop=%0b busy=%0b exp 0",
                           c, bus.fifo_ren, bus.buf_pop, bus.rd_busy);
      end
      if (c >= 1) begin
        checks++;
        if (bus.rd_udf_err !== 1'b1) begin
          errors++; $display("FAIL udf_sticky c=%0d: got %0b exp 1", c, bus.rd_udf_err);
        end
      end
      @(posedge clock); #1;
      bus.rd_start = 1'b0;
    end
    drive_idle();
    exp_udf = 1'b1;
    run_event(11'd7, 5'd1, 5'd2, 32'h0000_00AA, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_read();
    bus.rd_start = 1'b1; bus.buf_q_empty = 1'b0; bus.buf_queue_adr = 11'd500;
    bus.fifo_pretrig = 5'd3; bus.fifo_tbins = 5'd12; bus.buf_queue_data = 32'hCAFE_0001;
    @(posedge clock); #1;
    bus.rd_start = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
    end
    @(negedge clock);
    checks++;
    if (bus.fifo_ren !== 1'b1 || bus.rd_busy !== 1'b1) begin
      errors++; $display("FAIL pre_abort: got ren=%0b busy=%0b exp 1 1", bus.fifo_ren, bus.rd_busy);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.fifo_ren, bus.rd_busy, bus.rd_valid, bus.rd_udf_err} !== 4'b0 || bus.rd_event_cnt !== 16'd0) begin
      errors++; $display("FAIL abort_outputs: got ren=%0b busy=%0b valid=%0b udf=%0b cnt=%0d exp 0",
                         bus.fifo_ren, bus.rd_busy, bus.rd_valid, bus.rd_udf_err, bus.rd_event_cnt);
    end
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (bus.buf_pop !== 1'b0) begin
        errors++; $display("FAIL abort_pop: got %0b exp 0", bus.buf_pop);
      end
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    exp_evcnt = 0;
    exp_udf = 1'b0;
    run_event(11'd500, 5'd3, 5'd12, 32'hCAFE_0001, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_event(11'd2047, 5'd0, 5'd3, 32'h0000_0001, 0, 0, 1'b0, 1'b0);
    run_event(11'd0, 5'd31, 5'd31, 32'h0000_0002, 0, 0, 1'b0, 1'b0);
    run_event(11'd1024, 5'd16, 5'd1, 32'h0000_0003, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      run_event(11'($urandom), 5'($urandom), 5'($urandom), $urandom,
                int'($urandom_range(2, 10)), int'($urandom_range(0, 4)), 1'b1, 1'b1);
    end
  endtask

  task automatic test_final();
    @(negedge clock);
    checks++;
    if (bus.rd_event_cnt !== 16'(exp_evcnt)) begin
      errors++; $display("FAIL final_evcnt: got %0d exp %0d", bus.rd_event_cnt, exp_evcnt);
    end
    checks++;
    if (bus.rd_busy !== 1'b0 || bus.rd_udf_err !== exp_udf) begin
      errors++; $display("FAIL final_state: got busy=%0b udf=%0b exp 0 %0b", bus.rd_busy, bus.rd_udf_err, exp_udf);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_hold();
    test_zero_tbins();
    test_back_to_back();
    test_underflow();
    test_reset_mid_read();
    test_random();
    test_final();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
